// File: rtl/player_2_sync_if.sv
// Bundle between the remote-player receive path, the vblank source and the player-2 renderer.
// The master drives vblank and rx packets and observes the committed sprite; the controller is the slave.
interface player_2_sync_if;
    logic        vblnk;
    logic        rx_valid;
    logic [11:0] rx_x;
    logic [11:0] rx_y;
    logic        rx_flip_h;
    logic [1:0]  rx_class;
    logic [3:0]  rx_hp;

    logic [11:0] player_2_x;
    logic [11:0] player_2_y;
    logic        player_2_flip_h;
    logic [1:0]  player_2_class;
    logic [3:0]  player_2_hp;
    logic        player_2_data_valid;
    logic        player_2_visible;
    logic [1:0]  link_state;
    logic        rx_drop;

    modport master (
        output vblnk, rx_valid, rx_x, rx_y, rx_flip_h, rx_class, rx_hp,
        input  player_2_x, player_2_y, player_2_flip_h, player_2_class, player_2_hp,
        input  player_2_data_valid, player_2_visible, link_state, rx_drop
    );

    modport slave (
        input  vblnk, rx_valid, rx_x, rx_y, rx_flip_h, rx_class, rx_hp,
        output player_2_x, player_2_y, player_2_flip_h, player_2_class, player_2_hp,
        output player_2_data_valid, player_2_visible, link_state, rx_drop
    );
endinterface

// File: rtl/player_2_sync_ctrl.sv
// Player-2 sync sequencer: shadows remote packets and commits the newest one at vblank start.
// state | meaning: IDLE no packet yet | ACTIVE alive, hp>0 | DEAD hp==0 | STALE link timed out
module player_2_sync_ctrl #(
    parameter int TIMEOUT_FRAMES = 30,
    parameter int X_MAX          = 1023,
    parameter int Y_MAX          = 767,
    parameter int CHAR_LNG       = 19,
    parameter int CHAR_HGT       = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    player_2_sync_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DEAD   = 2'd2,
        S_STALE  = 2'd3
    } state_t;

    localparam int              CNT_W   = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_FRAMES);
    localparam logic [11:0]     X_LO    = 12'(CHAR_LNG);
    localparam logic [11:0]     X_HI    = 12'(X_MAX - CHAR_LNG);
    localparam logic [11:0]     Y_LO    = 12'(CHAR_HGT);
    localparam logic [11:0]     Y_HI    = 12'(Y_MAX - CHAR_HGT);

    state_t           r_state;
    logic             r_vblnk_d;
    logic             r_pending;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [11:0]      r_sh_x, r_sh_y;
    logic             r_sh_flip;
    logic [1:0]       r_sh_class;
    logic [3:0]       r_sh_hp;
    logic [11:0]      r_p2_x, r_p2_y;
    logic             r_p2_flip;
    logic [1:0]       r_p2_class;
    logic [3:0]       r_p2_hp;
    logic             r_data_valid;
    logic             r_visible;
    logic             r_drop;

    logic             w_tick, w_rx_ok, w_accept, w_commit;
    logic [11:0]      w_cx, w_cy;
    logic [11:0]      w_src_x, w_src_y;
    logic             w_src_flip;
    logic [1:0]       w_src_class;
    logic [3:0]       w_src_hp;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_tick   = bus.vblnk & ~r_vblnk_d;
    assign w_rx_ok  = (bus.rx_class == 2'd1 || bus.rx_class == 2'd2) &&
                      !(bus.rx_x == 12'd0 && bus.rx_y == 12'd0);
    assign w_accept = bus.rx_valid & w_rx_ok;
    assign w_commit = w_tick & (w_accept | r_pending);

    assign w_cx = (bus.rx_x < X_LO) ? X_LO : ((bus.rx_x > X_HI) ? X_HI : bus.rx_x);
    assign w_cy = (bus.rx_y < Y_LO) ? Y_LO : ((bus.rx_y > Y_HI) ? Y_HI : bus.rx_y);

    // A packet accepted on the tick edge bypasses the shadow and is committed directly.
    assign w_src_x     = w_accept ? w_cx          : r_sh_x;
    assign w_src_y     = w_accept ? w_cy          : r_sh_y;
    assign w_src_flip  = w_accept ? bus.rx_flip_h : r_sh_flip;
    assign w_src_class = w_accept ? bus.rx_class  : r_sh_class;
    assign w_src_hp    = w_accept ? bus.rx_hp     : r_sh_hp;

    assign w_cnt_inc = (r_frame_cnt == CNT_MAX) ? r_frame_cnt : r_frame_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_vblnk_d    <= 1'b0;
            r_pending    <= 1'b0;
            r_frame_cnt  <= '0;
            r_sh_x       <= '0;
            r_sh_y       <= '0;
            r_sh_flip    <= 1'b0;
            r_sh_class   <= '0;
            r_sh_hp      <= '0;
            r_p2_x       <= '0;
            r_p2_y       <= '0;
            r_p2_flip    <= 1'b0;
            r_p2_class   <= '0;
            r_p2_hp      <= '0;
            r_data_valid <= 1'b0;
            r_visible    <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_vblnk_d    <= bus.vblnk;
            r_drop       <= bus.rx_valid & ~w_rx_ok;
            r_data_valid <= w_commit;

            if (w_accept) begin
                r_sh_x     <= w_cx;
                r_sh_y     <= w_cy;
                r_sh_flip  <= bus.rx_flip_h;
                r_sh_class <= bus.rx_class;
                r_sh_hp    <= bus.rx_hp;
            end

            if (w_commit) begin
                r_pending   <= 1'b0;
                r_frame_cnt <= '0;
                r_p2_x      <= w_src_x;
                r_p2_y      <= w_src_y;
                r_p2_flip   <= w_src_flip;
                r_p2_class  <= w_src_class;
                r_p2_hp     <= w_src_hp;
                r_state     <= (w_src_hp != 4'd0) ? S_ACTIVE : S_DEAD;
                r_visible   <= (w_src_hp != 4'd0);
            end else begin
                if (w_accept) begin
                    r_pending <= 1'b1;
                end
                if (w_tick) begin
                    r_frame_cnt <= w_cnt_inc;
                    if (w_cnt_inc == CNT_MAX && (r_state == S_ACTIVE || r_state == S_DEAD)) begin
                        r_state   <= S_STALE;
                        r_visible <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.player_2_x          = r_p2_x;
    assign bus.player_2_y          = r_p2_y;
    assign bus.player_2_flip_h     = r_p2_flip;
    assign bus.player_2_class      = r_p2_class;
    assign bus.player_2_hp         = r_p2_hp;
    assign bus.player_2_data_valid = r_data_valid;
    assign bus.player_2_visible    = r_visible;
    assign bus.link_state          = r_state;
    assign bus.rx_drop             = r_drop;
endmodule
